// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the IF/ID stage: NOP encoding, opcode
// field bounds, buffer depth and performance-counter width.
package pipe_pkg;

  localparam logic [31:0] NOP_INST    = 32'h0;
  localparam int          OP_MSB      = 31;
  localparam int          OP_LSB      = 26;
  localparam int          OP_W        = OP_MSB - OP_LSB + 1;
  localparam int          IF_ID_DEPTH = 2;
  localparam int          CNT_W       = 16;

  // Occupancy needs to represent 0..IF_ID_DEPTH inclusive.
  localparam int          OCC_W       = 2;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(IF_ID_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_entry_t;

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/if_id_fifo.sv
// Two-entry storage for fetched {pc, inst} pairs with 1-bit read/write
// pointers. Push/pop qualification is done by the caller; clear_i empties
// the buffer and overrides push and pop.
module if_id_fifo
  import pipe_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  output logic [OCC_W-1:0] count_o,
  output logic [31:0]      head_pc_o,
  output logic [31:0]      head_inst_o
);

  if_id_entry_t [IF_ID_DEPTH-1:0] mem_q, mem_d;
  logic                           wr_ptr_q, wr_ptr_d;
  logic                           rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]               count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = '{pc: pc_i, inst: inst_i};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = mem_q[rd_ptr_q].pc;
  assign head_inst_o = mem_q[rd_ptr_q].inst;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: 2-entry valid/ready FIFO between fetch and decode
// with stall and flush handling. Optional stall/flush performance counters
// are built when IF_ID_PERF_CNT_EN is defined; otherwise they read as 0.
module if_id_buffer
  import pipe_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [5:0]  op_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  logic [OCC_W-1:0] count;
  logic [31:0]      head_pc;
  logic [31:0]      head_inst;
  logic             push;
  logic             pop;
  logic             not_empty;

  assign not_empty = (count != '0);
  assign ready_o   = (count < OCC_FULL) && !flush_i;
  assign valid_o   = not_empty && !stall_i && !flush_i;
  assign push      = valid_i && ready_o;
  assign pop       = valid_o && ready_i;

  if_id_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .pop_i       (pop),
    .clear_i     (flush_i),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .count_o     (count),
    .head_pc_o   (head_pc),
    .head_inst_o (head_inst)
  );

  // An empty buffer presents a NOP; otherwise the head is shown even while
  // valid_o is suppressed by stall or flush.
  assign pc_o   = not_empty ? head_pc   : 32'h0;
  assign inst_o = not_empty ? head_inst : NOP_INST;
  assign op_o   = inst_o[OP_MSB:OP_LSB];

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Count stalled cycles that actually hold an entry, and every flush cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_i && not_empty) stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush_i)              flush_cnt_d = sat_inc(flush_cnt_q);
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer. The driver issues one transaction per
// cycle and enqueues accepted entries into a reference queue; the monitor
// checks DUT outputs each falling edge against that queue.
module tb_if_id_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] pc_i = '0, inst_i = '0;
  logic        valid_i = 1'b0, ready_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic        ready_o, valid_o;
  logic [31:0] pc_o, inst_o;
  logic [5:0]  op_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  if_id_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .inst_i(inst_i),
    .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .inst_o(inst_o), .op_o(op_o), .stall_i(stall_i),
    .flush_i(flush_i), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];
  int   occ = 0;
  int   passed = 0;
  int   total = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  bit   mon_on = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare outputs with the reference queue, then retire the head
  // on a handshake or drop everything on a flush.
  initial begin
    ent_t        h;
    logic        e_valid;
    logic [31:0] e_pc, e_inst, e_op;
    forever begin
      @(negedge clk_i);
      if (!mon_on) break;
      occ     = q.size();
      e_valid = (occ > 0) && !stall_i && !flush_i;
      e_pc    = 32'h0;
      e_inst  = 32'h0;
      if (occ > 0) begin
        h      = q[0];
        e_pc   = h.pc;
        e_inst = h.inst;
      end
      e_op = {26'h0, e_inst[31:26]};
      chk("ready_o", {31'h0, ready_o}, {31'h0, (occ < 2) && !flush_i});
      chk("valid_o", {31'h0, valid_o}, {31'h0, e_valid});
      chk("pc_o", pc_o, e_pc);
      chk("inst_o", inst_o, e_inst);
      chk("op_o", {26'h0, op_o}, e_op);
      chk("stall_cnt_o", {16'h0, stall_cnt_o}, 32'(exp_stall));
      chk("flush_cnt_o", {16'h0, flush_cnt_o}, 32'(exp_flush));
      if (flush_i) q.delete();
      else if (e_valid && ready_i) void'(q.pop_front());
    end
  end

  // One cycle of stimulus; after the monitor has looked, record what the
  // coming clock edge must accept and count.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic st, input logic fl);
    ent_t e;
    @(posedge clk_i);
    #1;
    valid_i = v; pc_i = pc; inst_i = inst; ready_i = rdy; stall_i = st; flush_i = fl;
    @(negedge clk_i);
    #1;
    if (rst_i) begin
      if (v && !fl && occ < 2) begin
        e.pc = pc; e.inst = inst;
        q.push_back(e);
      end
`ifdef IF_ID_PERF_CNT_EN
      if (st && occ > 0 && exp_stall < 65535) exp_stall++;
      if (fl && exp_flush < 65535) exp_flush++;
`endif
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    valid_i = 1'b0; ready_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    q.delete();
    exp_stall = 0;
    exp_flush = 0;
    repeat (cycles) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] rp, ri;
    do_reset(3);

    // Single push, consumed next cycle; opcode 6'h08.
    cycle(1'b1, 32'h4, 32'h2002_0005, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Three offers with decode not ready: third refused; then drain.
    cycle(1'b1, 32'h8,  32'h1111_0001, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC,  32'h2222_0002, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h10, 32'h3333_0003, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Full buffer stalled for three cycles, then drained.
    cycle(1'b1, 32'h14, 32'h0C00_0014, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h18, 32'h8C00_0018, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Full buffer flushed while fetch offers a new word.
    cycle(1'b1, 32'h1C, 32'hAC00_001C, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h20, 32'h1000_0020, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h24, 32'hFFFF_0024, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Simultaneous push/pop at occupancy one, four times; pointers wrap.
    cycle(1'b1, 32'h28, 32'h0400_0028, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h2C + 32'(4 * i), 32'h0800_0000 | 32'(i), 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Reset with two entries held.
    cycle(1'b1, 32'h40, 32'h2400_0040, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h44, 32'h2800_0044, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    idle(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rp = $urandom;
      ri = $urandom;
      cycle(1'($urandom_range(0, 3) != 0), rp, ri,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 15) == 0));
    end
    idle(3, 1'b1);

    @(posedge clk_i);
    mon_on = 1'b0;
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have port: clk_i  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: pc_i  input  32  PC+4 of fetched instruction.
REQ-004 SHALL have port: inst_i  input  32  fetched instruction word.
REQ-005 SHALL have port: valid_i  input  1  fetch offers pc_i/inst_i this cycle.
REQ-006 SHALL have port: ready_o  output  1  buffer can accept this cycle.
REQ-007 SHALL have port: valid_o  output  1  head entry presented to decode.
REQ-008 SHALL have port: ready_i  input  1  decode consumes head this cycle.
REQ-009 SHALL have port: pc_o  output  32  head PC+4.
REQ-010 SHALL have port: inst_o  output  32  head instruction.
REQ-011 SHALL have port: op_o  output  6  inst_o[31:26], drives control-unit opcode input.
REQ-012 SHALL have port: stall_i  input  1  hazard-detection stall of decode.
REQ-013 SHALL have port: flush_i  input  1  branch/jump flush.
REQ-014 SHALL have port: stall_cnt_o  output  16  stall-cycle counter.
REQ-015 SHALL have port: flush_cnt_o  output  16  flush-event counter.

Function
REQ-016 SHALL hold a 2-entry FIFO of {pc, inst}; occupancy count 0..2.
REQ-017 SHALL drive ready_o = (count < 2) && !flush_i, combinationally.
REQ-018 SHALL push on valid_i && ready_o; pushed entry visible at outputs no earlier than next cycle (1-cycle latency).
REQ-019 SHALL drive valid_o = (count > 0) && !stall_i && !flush_i.
REQ-020 SHALL pop head on valid_o && ready_i; stall_i blocks pop, entries held unchanged.
REQ-021 Push and pop in same cycle with count==1 SHALL leave count 1, new entry becomes head next cycle.
REQ-022 When count==0, pc_o/inst_o/op_o SHALL be 0 (NOP), regardless of stall/flush.
REQ-023 When count>0, pc_o/inst_o SHALL show head even while valid_o low (stall/flush).
REQ-024 flush_i SHALL empty buffer at next edge (count 0); same-cycle input SHALL be dropped; flush overrides push, pop, stall.
REQ-025 Read/write pointers SHALL be 1 bit, wrapping 1->0.

Reset
REQ-026 While rst_i low: count 0, pointers 0, storage 0, pc_o/inst_o/op_o 0, valid_o 0, counters 0.
REQ-027 ready_o SHALL be 1 from first cycle after rst_i deasserts (flush_i low).
REQ-028 Reset mid-operation SHALL discard all entries immediately, no output glitch to valid_o=1.

Configuration
REQ-029 Macro IF_ID_PERF_CNT_EN defined: stall_cnt_o increments each cycle stall_i && count>0; flush_cnt_o increments each cycle flush_i; both saturate at 16'hFFFF.
REQ-030 Macro IF_ID_PERF_CNT_EN undefined: counters not built, stall_cnt_o and flush_cnt_o tied 0; ports retained.

Structure
REQ-031 Shared package pipe_pkg SHALL hold NOP_INST (32'h0), OP field bounds (31:26), IF_ID_DEPTH (2), CNT_W (16).
REQ-032 Storage/pointers SHALL be one sub-module if_id_fifo; stall/flush/counter logic stays in if_id_buffer.

Verification
REQ-033 Reset, then push inst 32'h2002_0005 pc 32'h4, ready_i=1 -> next cycle valid_o=1, inst_o=32'h2002_0005, op_o=6'h08, pc_o=32'h4.
REQ-034 ready_i=0, three consecutive valid_i -> first two accepted, ready_o=0 third cycle, third not stored; drain order preserved.
REQ-035 count 2, stall_i=1 for 3 cycles with ready_i=1 -> valid_o=0, no pop, contents unchanged; stall_cnt_o=3 when IF_ID_PERF_CNT_EN defined, 0 when undefined.
REQ-036 count 2, flush_i=1 with valid_i=1 -> next cycle count 0, valid_o=0, inst_o=0, flush_cnt_o=1 (macro defined).
REQ-037 count 1, push and pop same cycle, repeated 4 cycles -> count stays 1, pointer wrap verified, in-order delivery.
REQ-038 rst_i low mid-drain with count 2 -> valid_o=0, outputs 0 immediately; after release ready_o=1, count 0.
